// File: rtl/conv_window_sequencer.sv
// Walks every filter placement over a data matrix, emitting one (data, filter) address beat per transfer.
// First beat 2 cycles after start, then 1 beat/cycle; a stalled beat (readyIn=0) holds every output.
module conv_window_sequencer #(
   parameter int ADDR_WIDTH = 12,
   parameter int DIM_WIDTH  = 8
) (
   input  logic                   clkIn,
   input  logic                   rstIn,
   input  logic                   startIn,
   input  logic [DIM_WIDTH-1:0]   dataRowsIn,
   input  logic [DIM_WIDTH-1:0]   dataColsIn,
   input  logic [DIM_WIDTH-1:0]   filtRowsIn,
   input  logic [DIM_WIDTH-1:0]   filtColsIn,
   input  logic [ADDR_WIDTH-1:0]  dataBaseIn,
   input  logic [ADDR_WIDTH-1:0]  filtBaseIn,
   input  logic                   readyIn,
   output logic                   validOut,
   output logic [ADDR_WIDTH-1:0]  dataAddrOut,
   output logic [ADDR_WIDTH-1:0]  filtAddrOut,
   output logic                   lastOut,
   output logic [2*DIM_WIDTH-1:0] outIdxOut,
   output logic                   busyOut,
   output logic                   doneOut,
   output logic                   errOut
);

   typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

   localparam logic [DIM_WIDTH-1:0]   D_ONE = 1;
   localparam logic [ADDR_WIDTH-1:0]  A_ONE = 1;
   localparam logic [2*DIM_WIDTH-1:0] I_ONE = 1;

   state_t                  state_q;
   logic [DIM_WIDTH-1:0]    dr_q, dc_q, fr_q, fc_q, or_q, oc_q;
   logic [DIM_WIDTH-1:0]    orow_q, ocol_q, kr_q, kc_q;
   logic [ADDR_WIDTH-1:0]   dbase_q, fbase_q;
   // wrow: first window of the current output row; win: window top-left; drow/frow: current filter row start
   logic [ADDR_WIDTH-1:0]   wrow_q, win_q, drow_q, frow_q;
   logic [ADDR_WIDTH-1:0]   data_addr_q, filt_addr_q;
   logic [2*DIM_WIDTH-1:0]  out_idx_q;
   logic                    valid_q, last_q, busy_q, done_q, err_q;

   logic                    xfer, kc_end, kr_end, ocol_end, orow_end, bad_cfg;
   logic [ADDR_WIDTH-1:0]   dc_a, fc_a;

   assign xfer     = valid_q & readyIn;
   assign kc_end   = (kc_q == fc_q - D_ONE);
   assign kr_end   = (kr_q == fr_q - D_ONE);
   assign ocol_end = (ocol_q == oc_q - D_ONE);
   assign orow_end = (orow_q == or_q - D_ONE);
   assign dc_a     = ADDR_WIDTH'(dc_q);
   assign fc_a     = ADDR_WIDTH'(fc_q);
   assign bad_cfg  = (dr_q == '0) || (dc_q == '0) || (fr_q == '0) || (fc_q == '0) ||
                     (fr_q > dr_q) || (fc_q > dc_q);

   always_ff @(posedge clkIn) begin
      if (!rstIn) begin
         state_q <= S_IDLE;
         dr_q <= '0;  dc_q <= '0;  fr_q <= '0;  fc_q <= '0;  or_q <= '0;  oc_q <= '0;
         orow_q <= '0;  ocol_q <= '0;  kr_q <= '0;  kc_q <= '0;
         dbase_q <= '0;  fbase_q <= '0;  wrow_q <= '0;  win_q <= '0;  drow_q <= '0;  frow_q <= '0;
         data_addr_q <= '0;  filt_addr_q <= '0;  out_idx_q <= '0;
         valid_q <= 1'b0;  last_q <= 1'b0;  busy_q <= 1'b0;  done_q <= 1'b0;  err_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (startIn) begin
                  dr_q    <= dataRowsIn;
                  dc_q    <= dataColsIn;
                  fr_q    <= filtRowsIn;
                  fc_q    <= filtColsIn;
                  dbase_q <= dataBaseIn;
                  fbase_q <= filtBaseIn;
                  busy_q  <= 1'b1;
                  state_q <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (bad_cfg) begin
                  err_q   <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  or_q        <= dr_q - fr_q + D_ONE;
                  oc_q        <= dc_q - fc_q + D_ONE;
                  orow_q      <= '0;
                  ocol_q      <= '0;
                  kr_q        <= '0;
                  kc_q        <= '0;
                  wrow_q      <= dbase_q;
                  win_q       <= dbase_q;
                  drow_q      <= dbase_q;
                  frow_q      <= fbase_q;
                  data_addr_q <= dbase_q;
                  filt_addr_q <= fbase_q;
                  out_idx_q   <= '0;
                  last_q      <= (fr_q == D_ONE) && (fc_q == D_ONE);
                  valid_q     <= 1'b1;
                  state_q     <= S_RUN;
               end
            end
            S_RUN: begin
               if (xfer) begin
                  if (!kc_end) begin
                     kc_q        <= kc_q + D_ONE;
                     data_addr_q <= data_addr_q + A_ONE;
                     filt_addr_q <= filt_addr_q + A_ONE;
                     last_q      <= kr_end && (kc_q + D_ONE == fc_q - D_ONE);
                  end else if (!kr_end) begin
                     kc_q        <= '0;
                     kr_q        <= kr_q + D_ONE;
                     drow_q      <= drow_q + dc_a;
                     data_addr_q <= drow_q + dc_a;
                     frow_q      <= frow_q + fc_a;
                     filt_addr_q <= frow_q + fc_a;
                     last_q      <= (kr_q + D_ONE == fr_q - D_ONE) && (fc_q == D_ONE);
                  end else if (ocol_end && orow_end) begin
                     valid_q <= 1'b0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     // Window finished: rewind the filter and step to the next placement.
                     kc_q        <= '0;
                     kr_q        <= '0;
                     frow_q      <= fbase_q;
                     filt_addr_q <= fbase_q;
                     out_idx_q   <= out_idx_q + I_ONE;
                     last_q      <= (fr_q == D_ONE) && (fc_q == D_ONE);
                     if (!ocol_end) begin
                        ocol_q      <= ocol_q + D_ONE;
                        win_q       <= win_q + A_ONE;
                        drow_q      <= win_q + A_ONE;
                        data_addr_q <= win_q + A_ONE;
                     end else begin
                        ocol_q      <= '0;
                        orow_q      <= orow_q + D_ONE;
                        wrow_q      <= wrow_q + dc_a;
                        win_q       <= wrow_q + dc_a;
                        drow_q      <= wrow_q + dc_a;
                        data_addr_q <= wrow_q + dc_a;
                     end
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign validOut    = valid_q;
   assign dataAddrOut = data_addr_q;
   assign filtAddrOut = filt_addr_q;
   assign lastOut     = last_q;
   assign outIdxOut   = out_idx_q;
   assign busyOut     = busy_q;
   assign doneOut     = done_q;
   assign errOut      = err_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Scoreboard bench for conv_window_sequencer: stimulus queues expected beats, a negedge monitor pops and compares.
module tb_conv_window_sequencer;

   logic        clk, rstIn, startIn, readyIn;
   logic [7:0]  dataRowsIn, dataColsIn, filtRowsIn, filtColsIn;
   logic [11:0] dataBaseIn, filtBaseIn;
   logic        validOut, lastOut, busyOut, doneOut, errOut;
   logic [11:0] dataAddrOut, filtAddrOut;
   logic [15:0] outIdxOut;

   conv_window_sequencer #(.ADDR_WIDTH(12), .DIM_WIDTH(8)) dut (
      .clkIn(clk), .rstIn(rstIn), .startIn(startIn),
      .dataRowsIn(dataRowsIn), .dataColsIn(dataColsIn),
      .filtRowsIn(filtRowsIn), .filtColsIn(filtColsIn),
      .dataBaseIn(dataBaseIn), .filtBaseIn(filtBaseIn),
      .readyIn(readyIn), .validOut(validOut),
      .dataAddrOut(dataAddrOut), .filtAddrOut(filtAddrOut),
      .lastOut(lastOut), .outIdxOut(outIdxOut),
      .busyOut(busyOut), .doneOut(doneOut), .errOut(errOut)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] d;
      logic [11:0] f;
      logic        l;
      logic [15:0] idx;
      logic        fin;
   } beat_t;

   beat_t exp_q[$];
   int    checks = 0;
   int    errors = 0;
   int    beats_seen = 0;
   int    rdy_mode = 0;
   logic  last_stalled = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_beat(input int d, input int f, input bit l, input int idx, input bit fin);
      beat_t b;
      b.d = 12'(d);  b.f = 12'(f);  b.l = l;  b.idx = 16'(idx);  b.fin = fin;
      exp_q.push_back(b);
   endtask

   // Reference walk straight from the address formulas.
   task automatic push_job(input int dr, input int dc, input int fr, input int fc, input int db, input int fb);
      int orr, occ;
      orr = dr - fr + 1;
      occ = dc - fc + 1;
      for (int orow = 0; orow < orr; orow++)
         for (int ocol = 0; ocol < occ; ocol++)
            for (int kr = 0; kr < fr; kr++)
               for (int kc = 0; kc < fc; kc++)
                  push_beat(db + (orow + kr) * dc + ocol + kc, fb + kr * fc + kc,
                            (kr == fr - 1) && (kc == fc - 1), orow * occ + ocol,
                            (kr == fr - 1) && (kc == fc - 1) && (orow == orr - 1) && (ocol == occ - 1));
   endtask

   // Ready driver: 0 always ready, 1 pseudo-random with a forced stall on one lastOut beat, 2 never ready.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: readyIn = 1'b1;
         1: begin
            if (validOut && lastOut && !last_stalled) begin
               readyIn = 1'b0;
               last_stalled = 1'b1;
            end else begin
               readyIn = 1'($urandom_range(0, 1));
            end
         end
         default: readyIn = 1'b0;
      endcase
   end

   // Monitor
   logic        prev_stall = 1'b0;
   logic        done_pend = 1'b0;
   logic [11:0] h_d, h_f;
   logic        h_l;
   logic [15:0] h_idx;

   always @(negedge clk) begin
      if (!rstIn) begin
         prev_stall = 1'b0;
         done_pend  = 1'b0;
      end else begin
         if (done_pend) begin
            chk("done_after_final_beat", doneOut, 1);
            done_pend = 1'b0;
         end else if (doneOut) begin
            chk("done_unexpected", doneOut, 0);
         end
         if (prev_stall) begin
            chk("stall_valid_held", validOut, 1);
            chk("stall_data_held", dataAddrOut, h_d);
            chk("stall_filt_held", filtAddrOut, h_f);
            chk("stall_last_held", lastOut, h_l);
            chk("stall_idx_held", outIdxOut, h_idx);
         end
         if (validOut && readyIn) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat_count", 1, 0);
            end else begin
               beat_t b;
               b = exp_q.pop_front();
               chk("beat_data_addr", dataAddrOut, b.d);
               chk("beat_filt_addr", filtAddrOut, b.f);
               chk("beat_last", lastOut, b.l);
               chk("beat_out_idx", outIdxOut, b.idx);
               done_pend = b.fin;
            end
            beats_seen++;
         end
         prev_stall = validOut && !readyIn;
         h_d = dataAddrOut;  h_f = filtAddrOut;  h_l = lastOut;  h_idx = outIdxOut;
      end
   end

   task automatic start_job(input int dr, input int dc, input int fr, input int fc,
                            input int db, input int fb, input bit hold, input bit expect_err);
      dataRowsIn = 8'(dr);  dataColsIn = 8'(dc);
      filtRowsIn = 8'(fr);  filtColsIn = 8'(fc);
      dataBaseIn = 12'(db); filtBaseIn = 12'(fb);
      startIn = 1'b1;
      beats_seen = 0;
      @(posedge clk); #1;
      startIn = hold;
      // Scramble config so latching, not live inputs, is exercised.
      dataRowsIn = 8'd0;  dataColsIn = 8'd0;  dataBaseIn = 12'd555;
      chk("check_busy", busyOut, 1);
      chk("check_valid_low", validOut, 0);
      @(posedge clk); #1;
      if (expect_err) begin
         chk("err_pulse", errOut, 1);
         chk("err_busy_low", busyOut, 0);
         chk("err_valid_low", validOut, 0);
         @(posedge clk); #1;
         chk("err_one_cycle", errOut, 0);
         chk("err_no_valid", validOut, 0);
      end else begin
         chk("first_valid_2_cycles", validOut, 1);
      end
   endtask

   task automatic wait_done(input int max_cycles);
      int n;
      n = 0;
      while (!doneOut && n < max_cycles) begin
         @(posedge clk); #1;
         n++;
      end
      chk("done_seen_before_timeout", doneOut, 1);
      chk("done_valid_low", validOut, 0);
      chk("done_busy_high", busyOut, 1);
      startIn = 1'b0;
      @(posedge clk); #1;
      chk("idle_busy_low", busyOut, 0);
      chk("idle_done_low", doneOut, 0);
      chk("all_beats_consumed", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int d1[16];
      rstIn = 1'b0;  startIn = 1'b0;  readyIn = 1'b1;
      dataRowsIn = '0; dataColsIn = '0; filtRowsIn = '0; filtColsIn = '0;
      dataBaseIn = '0; filtBaseIn = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", validOut, 0);
      chk("rst_busy", busyOut, 0);
      chk("rst_done", doneOut, 0);
      chk("rst_err", errOut, 0);
      chk("rst_data_addr", dataAddrOut, 0);
      chk("rst_out_idx", outIdxOut, 0);
      rstIn = 1'b1;
      @(posedge clk); #1;

      // 1: basic 3x3 / 2x2 walk with hand-listed addresses.
      d1 = '{0, 1, 3, 4, 1, 2, 4, 5, 3, 4, 6, 7, 4, 5, 7, 8};
      for (int i = 0; i < 16; i++)
         push_beat(d1[i], 100 + (i % 4), (i % 4) == 3, i / 4, i == 15);
      start_job(3, 3, 2, 2, 0, 100, 1'b0, 1'b0);
      wait_done(100);
      chk("s1_beat_total", beats_seen, 16);

      // 2: same job under backpressure.
      rdy_mode = 1;  last_stalled = 1'b0;
      push_job(3, 3, 2, 2, 0, 100);
      start_job(3, 3, 2, 2, 0, 100, 1'b0, 1'b0);
      wait_done(400);
      chk("s2_beat_total", beats_seen, 16);
      chk("s2_last_stall_hit", last_stalled, 1);
      rdy_mode = 0;

      // 3: degenerate shapes.
      for (int i = 0; i < 6; i++) push_beat(i, 50, 1'b1, i, i == 5);
      start_job(2, 3, 1, 1, 0, 50, 1'b0, 1'b0);
      wait_done(100);
      chk("s3a_beat_total", beats_seen, 6);
      push_job(4, 4, 4, 4, 10, 200);
      start_job(4, 4, 4, 4, 10, 200, 1'b0, 1'b0);
      wait_done(100);
      chk("s3b_beat_total", beats_seen, 16);

      // 4: rejected jobs.
      start_job(3, 3, 4, 1, 0, 0, 1'b0, 1'b1);
      start_job(3, 0, 1, 1, 0, 0, 1'b0, 1'b1);
      chk("s4_no_beats", beats_seen, 0);

      // 5: start held through a run, then a new job right after done.
      push_job(3, 3, 2, 2, 20, 300);
      start_job(3, 3, 2, 2, 20, 300, 1'b1, 1'b0);
      wait_done(100);
      chk("s5_held_beat_total", beats_seen, 16);
      push_job(2, 3, 1, 1, 7, 9);
      start_job(2, 3, 1, 1, 7, 9, 1'b0, 1'b0);
      wait_done(100);
      chk("s5_back_to_back_total", beats_seen, 6);

      // 5: reset mid-job after beat 5.
      push_job(3, 3, 2, 2, 0, 100);
      start_job(3, 3, 2, 2, 0, 100, 1'b0, 1'b0);
      for (int i = 0; i < 200 && beats_seen < 5; i++) @(posedge clk);
      chk("s5_reached_beat5", beats_seen >= 5, 1);
      @(posedge clk); #1;
      rstIn = 1'b0;
      @(posedge clk); #1;
      chk("abort_valid", validOut, 0);
      chk("abort_busy", busyOut, 0);
      chk("abort_done", doneOut, 0);
      chk("abort_last", lastOut, 0);
      chk("abort_data_addr", dataAddrOut, 0);
      chk("abort_filt_addr", filtAddrOut, 0);
      exp_q.delete();
      rstIn = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("abort_no_done_later", doneOut, 0);
      end

      // 6: data address wraps modulo 4096.
      push_beat(4094, 7, 1'b1, 0, 1'b0);
      push_beat(4095, 7, 1'b1, 1, 1'b0);
      push_beat(0, 7, 1'b1, 2, 1'b0);
      push_beat(1, 7, 1'b1, 3, 1'b1);
      start_job(2, 2, 1, 1, 4094, 7, 1'b0, 1'b0);
      wait_done(100);
      chk("s6_beat_total", beats_seen, 4);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
- Control sequencer for the convolution MAC datapath.
- Takes a convolution job (data matrix dimensions, filter dimensions, RAM base addresses) and walks every valid filter placement over the data matrix.
- Emits one (data element address, filter element address) pair per accepted beat, with a last flag at the end of each window, so the MAC closes one output sum per window.
- Sits between the RISC-V configuration registers and the element RAM read ports / MAC input.

Parameters:
- ADDR_WIDTH, 12, element address width (MAX_SIZE 4096 elements).
- DIM_WIDTH, 8, width of each row/column dimension field.

Ports:
- clkIn  input  1  clock.
- rstIn  input  1  synchronous, active-low reset.
- startIn  input  1  start job; sampled only in IDLE.
- dataRowsIn  input  DIM_WIDTH  data matrix rows (DR).
- dataColsIn  input  DIM_WIDTH  data matrix columns (DC).
- filtRowsIn  input  DIM_WIDTH  filter rows (FR).
- filtColsIn  input  DIM_WIDTH  filter columns (FC).
- dataBaseIn  input  ADDR_WIDTH  element address of data[0][0].
- filtBaseIn  input  ADDR_WIDTH  element address of filt[0][0].
- readyIn  input  1  downstream accepts the current beat.
- validOut  output  1  beat valid.
- dataAddrOut  output  ADDR_WIDTH  data element address.
- filtAddrOut  output  ADDR_WIDTH  filter element address.
- lastOut  output  1  final beat of the current window.
- outIdxOut  output  2*DIM_WIDTH  output element index of the current window.
- busyOut  output  1  job in progress.
- doneOut  output  1  one-cycle pulse when the job completes.
- errOut  output  1  one-cycle pulse when a job is rejected.

Behaviour:
- Reset (rstIn=0 at a clock edge): state goes to IDLE. All outputs go to 0. This applies from any state, including mid-job. No done or err pulse is produced for an aborted job.
- Derived values: OR = DR-FR+1, OC = DC-FC+1.
- States: IDLE, CHECK, RUN, DONE.
- IDLE:
  - busyOut=0.
  - startIn=1 latches all configuration inputs, sets busyOut=1 and moves to CHECK.
  - Configuration inputs are ignored at all other times. startIn while busy has no effect.
- CHECK (1 cycle):
  - If any dimension is 0, or FR>DR, or FC>DC: pulse errOut, drop busyOut and return to IDLE.
  - Otherwise load counters orow=ocol=kr=kc=0, register the first beat with validOut=1, and move to RUN.
  - validOut is therefore first high on the 2nd cycle after startIn is sampled.
- Beat contents:
  - dataAddrOut = dataBase + (orow+kr)*DC + (ocol+kc).
  - filtAddrOut = filtBase + kr*FC + kc.
  - outIdxOut = orow*OC + ocol.
  - lastOut = (kr==FR-1 && kc==FC-1).
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap is silent.
  - All outputs are registered. Addresses are maintained incrementally (row-stride adds), with no multiplier in the per-beat path.
- Iteration order: kc is innermost, then kr, then ocol, then orow outermost. Total beats per job = OR*OC*FR*FC.
- Handshake:
  - A beat transfers on a cycle with validOut && readyIn.
  - While validOut=1 && readyIn=0, every beat output holds stable.
  - validOut, once asserted, does not drop until the transfer occurs.
  - Back-to-back beats run at 1 per cycle while readyIn=1.
- Completion:
  - The transfer of the beat with orow=OR-1, ocol=OC-1 and lastOut=1 moves the state to DONE.
  - validOut=0 from the next cycle.
- DONE (1 cycle): doneOut=1, then busyOut=0 and return to IDLE. A startIn in that IDLE cycle is accepted normally.
- readyIn is ignored while validOut=0.

Test Plan:
1. Basic window walk. DR=DC=3, FR=FC=2, dataBase=0, filtBase=100, readyIn=1.
   - Exactly 16 beats.
   - Window 0: dataAddr 0,1,3,4; filtAddr 100,101,102,103; lastOut only on the 4th beat; outIdx=0.
   - Window 3: dataAddr 4,5,7,8; outIdx=3.
   - doneOut pulses 1 cycle after the 16th transfer. validOut is first high 2 cycles after start.
2. Backpressure. Same job with readyIn toggled pseudo-randomly, including a stall on a lastOut beat.
   - Beat sequence identical to scenario 1.
   - Outputs stable during every stall. Still 16 transfers, no duplicates or drops.
3. Degenerate shapes.
   - FR=FC=1, DR=2, DC=3: 6 beats, each with lastOut=1, dataAddr 0..5, filtAddr constant, outIdx 0..5.
   - FR=DR=FC=DC=4: one window of 16 beats, lastOut only on beat 16, outIdx=0.
4. Error rejection.
   - FR=4, DR=3: errOut pulses 1 cycle, validOut never asserts, busyOut returns to 0.
   - DC=0: same response.
5. Reset and start interlock.
   - Assert rstIn=0 mid-job at beat 5: next cycle all outputs are 0, no doneOut.
   - startIn held high during a run does not restart or alter the beat sequence.
   - A startIn in the cycle after doneOut begins a new job.
6. Address wrap. ADDR_WIDTH=12, dataBase=4094, DR=DC=2, FR=FC=1.
   - dataAddr sequence is 4094, 4095, 0, 1.
